// File: rtl/riscv_multicycle_ctrl_if.sv
// Shared single-port memory request/ack bus between the multi-cycle controller
// and memory.
interface riscv_multicycle_ctrl_if;
  logic mem_req_o;
  logic mem_we_o;
  logic mem_addr_sel_o;
  logic mem_ack_i;

  modport master (output mem_req_o, output mem_we_o, output mem_addr_sel_o, input mem_ack_i);
  modport slave  (input mem_req_o, input mem_we_o, input mem_addr_sel_o, output mem_ack_i);
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// RV64 multi-cycle control FSM: fetch/decode/exec/mem/wb over a req/ack memory.
// Optional RISCV_CTRL_PERF_EN adds cycle and retired-instruction counters.
module riscv_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        branch_taken_i,
  riscv_multicycle_ctrl_if.master bus,
  output logic        ir_load_o,
  output logic        mdr_load_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [2:0]  state_o
`ifdef RISCV_CTRL_PERF_EN
  ,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  logic [2:0]           state, nxt;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 illegal_q, bus_err_q;
  logic                 set_ill, set_berr, wd_run, retire;
  logic                 req, we, addr_sel;
  logic                 is_r, is_i, is_ld, is_sd, is_br, legal, ack, wd_hit;

  assign is_r   = (instr_i[6:0] == OP_R);
  assign is_i   = (instr_i[6:0] == OP_I);
  assign is_ld  = (instr_i[6:0] == OP_LD);
  assign is_sd  = (instr_i[6:0] == OP_SD);
  assign is_br  = (instr_i[6:0] == OP_BR);
  assign legal  = is_r | is_i | is_ld | is_sd | is_br;
  assign ack    = bus.mem_ack_i;
  // Fires on the last allowed wait cycle; an ack in the same cycle takes priority.
  assign wd_hit = WD_EN && (wd_cnt == WD_LAST);

  always_comb begin
    nxt          = state;
    req          = 1'b0;
    we           = 1'b0;
    addr_sel     = 1'b0;
    ir_load_o    = 1'b0;
    mdr_load_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    alu_src_b_o  = 1'b0;
    alu_op_o     = 2'b00;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    set_ill      = 1'b0;
    set_berr     = 1'b0;
    wd_run       = 1'b0;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        if (ack) begin
          ir_load_o  = 1'b1;
          pc_write_o = 1'b1;
          nxt        = S_DECODE;
        end else if (wd_hit) begin
          nxt      = S_TRAP;
          set_berr = 1'b1;
        end else begin
          wd_run = 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) nxt = S_EXEC;
        else begin
          nxt     = S_TRAP;
          set_ill = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_op_o = 2'b10;
          nxt      = S_WB;
        end else if (is_i) begin
          alu_src_b_o = 1'b1;
          alu_op_o    = 2'b10;
          nxt         = S_WB;
        end else if (is_ld || is_sd) begin
          alu_src_b_o = 1'b1;
          nxt         = S_MEM;
        end else if (is_br) begin
          alu_op_o = 2'b01;
          if (branch_taken_i) begin
            pc_write_o = 1'b1;
            pc_src_o   = 1'b1;
          end
          nxt    = S_FETCH;
          retire = 1'b1;
        end else begin
          // IR changed under us after decode; treat as illegal rather than guess.
          nxt     = S_TRAP;
          set_ill = 1'b1;
        end
      end
      S_MEM: begin
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = is_sd;
        if (ack) begin
          if (is_sd) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end else begin
            mdr_load_o = 1'b1;
            nxt        = S_WB;
          end
        end else if (wd_hit) begin
          nxt      = S_TRAP;
          set_berr = 1'b1;
        end else begin
          wd_run = 1'b1;
        end
      end
      S_WB: begin
        reg_write_o  = (instr_i[11:7] != 5'd0);
        mem_to_reg_o = is_ld;
        nxt          = S_FETCH;
        retire       = 1'b1;
      end
      S_TRAP: nxt = S_TRAP;
      default: begin
        nxt     = S_TRAP;
        set_ill = 1'b1;
      end
    endcase
    // Reset silences everything in the same cycle, including a pending request.
    if (rst_i) begin
      req          = 1'b0;
      we           = 1'b0;
      addr_sel     = 1'b0;
      ir_load_o    = 1'b0;
      mdr_load_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 1'b0;
      alu_src_b_o  = 1'b0;
      alu_op_o     = 2'b00;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      retire       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_FETCH;
      wd_cnt    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= nxt;
      wd_cnt    <= wd_run ? wd_cnt + 1'b1 : '0;
      illegal_q <= illegal_q | set_ill;
      bus_err_q <= bus_err_q | set_berr;
    end
  end

  assign bus.mem_req_o      = req;
  assign bus.mem_we_o       = we;
  assign bus.mem_addr_sel_o = addr_sel;
  assign illegal_o          = illegal_q & ~rst_i;
  assign bus_err_o          = bus_err_q & ~rst_i;
  assign state_o            = rst_i ? 3'd0 : state;

`ifdef RISCV_CTRL_PERF_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != S_TRAP) cycle_q <= cycle_q + 64'd1;
      if (retire)          instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt_o = rst_i ? 64'd0 : cycle_q;
  assign instret_o   = rst_i ? 64'd0 : instret_q;
`endif

endmodule
